// File: rtl/instr_encoder_pkg.sv
// arm_enc_pkg: shared class codes, encoding tags and FSM state constants for instr_encoder.
package arm_enc_pkg;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;
    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ILL = 2'b11;
    localparam logic [3:0] MUL_TAG = 4'b1001;
    localparam logic [3:0] DIV_TAG = 4'b0001;
    localparam logic [3:0] PC_REG  = 4'hF;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request/control bus from the program source plus imem write port and status.
interface instr_encoder_if #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic              start, req_valid, req_ready, req_last, req_md;
    logic [1:0]        req_class;
    logic [3:0]        req_cond, req_rd, req_rn, req_rm, req_rs;
    logic [5:0]        req_funct;
    logic [23:0]       req_imm;
    logic              imem_we, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [CNT_W-1:0]  count;
    modport master(
        output start, req_valid, req_last, req_md, req_class, req_cond, req_rd, req_rn, req_rm, req_rs,
               req_funct, req_imm,
        input  req_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
    );
    modport slave(
        input  start, req_valid, req_last, req_md, req_class, req_cond, req_rd, req_rn, req_rm, req_rs,
               req_funct, req_imm,
        output req_ready, imem_we, imem_addr, imem_wdata, count, busy, done, err
    );
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational request fields -> 32-bit ARM word plus illegal flag.
// ENC_MULDIV_EN enables the MUL/DIV forms; without it any md request is illegal.
module instr_pack
    import arm_enc_pkg::*;
(
    input  logic [1:0]  cls_i,
    input  logic        md_i,
    input  logic [3:0]  cond_i,
    input  logic [5:0]  funct_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  rn_i,
    input  logic [3:0]  rm_i,
    input  logic [3:0]  rs_i,
    input  logic [23:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);
    logic [31:0] dp_w, mem_w, br_w, base_w;
    logic        reg_form, base_ill;
    assign dp_w   = {cond_i, 2'b00, funct_i, rn_i, rd_i, funct_i[5] ? imm_i[11:0] : {imm_i[11:4], rm_i}};
    assign mem_w  = {cond_i, 2'b01, funct_i, rn_i, rd_i, funct_i[5] ? {imm_i[11:4], rm_i} : imm_i[11:0]};
    assign br_w   = {cond_i, 3'b101, funct_i[4], imm_i};
    assign base_w = (cls_i == CLS_DP) ? dp_w : (cls_i == CLS_MEM) ? mem_w : br_w;
    // a register-form operand with bits [7:4]==1001 would decode as a multiply
    assign reg_form = (cls_i == CLS_DP) ? ~funct_i[5] : ((cls_i == CLS_MEM) & funct_i[5]);
    assign base_ill = (cls_i == CLS_ILL) | (reg_form & (imm_i[7:4] == MUL_TAG));
`ifdef ENC_MULDIV_EN
    logic [31:0] mul_w, div_w;
    assign mul_w     = {cond_i, 4'b0000, funct_i[3:0], rd_i, rn_i, rs_i, MUL_TAG, rm_i};
    assign div_w     = {cond_i, 2'b01, 4'b1100, funct_i[1], 1'b1, rn_i, PC_REG, rs_i, DIV_TAG, rm_i};
    assign word_o    = md_i ? ((cls_i == CLS_DP) ? mul_w : div_w) : base_w;
    assign illegal_o = md_i ? ((cls_i == CLS_BR) | (cls_i == CLS_ILL)) : base_ill;
`else
    assign word_o    = base_w;
    assign illegal_o = md_i | base_ill;
`endif
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level requests and writes encoded ARM words sequentially into imem.
// Optional MUL/DIV encodings are enabled by defining ENC_MULDIV_EN.
module instr_encoder
    import arm_enc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                DEPTH     = 64
) (
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d, word;
    logic              we_q, we_d, err_q, err_d, illegal, ready, fire;
    instr_pack u_pack (
        .cls_i    (bus.req_class),
        .md_i     (bus.req_md),
        .cond_i   (bus.req_cond),
        .funct_i  (bus.req_funct),
        .rd_i     (bus.req_rd),
        .rn_i     (bus.req_rn),
        .rm_i     (bus.req_rm),
        .rs_i     (bus.req_rs),
        .imm_i    (bus.req_imm),
        .word_o   (word),
        .illegal_o(illegal)
    );
    assign ready = (state_q == ST_RUN) & (count_q < CNT_W'(DEPTH)) & ~bus.start;
    assign fire  = bus.req_valid & ready;
    // count advances at accept so req_ready already sees a write still in flight
    always_comb begin
        we_d    = fire & ~illegal;
        wdata_d = we_d ? word : wdata_q;
        count_d = bus.start ? '0 : count_q + CNT_W'(we_d);
        addr_d  = bus.start ? BASE_ADDR : (we_q ? addr_q + ADDR_W'(4) : addr_q);
        err_d   = ~bus.start & (err_q | (fire & illegal));
        state_d = bus.start ? ST_RUN :
                  (fire & (bus.req_last | (count_d == CNT_W'(DEPTH)))) ? ST_DONE : state_q;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end
    assign bus.req_ready  = ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.count      = count_q;
    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.err        = err_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a field-arithmetic model.
module tb_instr_encoder;
    typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
`ifdef ENC_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_tests = 0;
    int n_fail = 0;
    mstate_t m_state = M_IDLE;
    int unsigned m_addr = 0;
    int m_count = 0;
    bit m_err = 0;
    always #5 clk = ~clk;
    instr_encoder_if #(.ADDR_W(32), .DEPTH(64)) m ();
    instr_encoder_if #(.ADDR_W(32), .DEPTH(2))  s ();
    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(64)) u_dut (.clk(clk), .reset(rst_n), .bus(m));
    instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(2))  u_small (.clk(clk), .reset(rst_n), .bus(s));

    function automatic void ref_encode(input logic [1:0] cls, input logic md, input logic [3:0] cond,
                                       input logic [5:0] funct, input logic [3:0] rd, rn, rm, rs,
                                       input logic [23:0] imm, output logic [31:0] w, output logic ill);
        int unsigned low;
        bit regf;
        w = 0;
        ill = 0;
        if (cls == 3) ill = 1;
        else if (cls == 2) begin
            if (md) ill = 1;
            else w = (32'(cond) << 28) | (32'd5 << 25) | (32'(funct[4]) << 24) | 32'(imm);
        end else if (md) begin
            if (!MD_EN) ill = 1;
            else if (cls == 0)
                w = (32'(cond) << 28) | (32'(funct[3:0]) << 20) | (32'(rd) << 16) | (32'(rn) << 12)
                  | (32'(rs) << 8) | (32'd9 << 4) | 32'(rm);
            else
                w = (32'(cond) << 28) | (32'd1 << 26) | (32'd12 << 22) | (32'(funct[1]) << 21) | (32'd1 << 20)
                  | (32'(rn) << 16) | (32'd15 << 12) | (32'(rs) << 8) | (32'd1 << 4) | 32'(rm);
        end else begin
            regf = (cls == 0) ? !funct[5] : funct[5];
            low = regf ? ((((32'(imm) >> 4) & 32'hFF) << 4) | 32'(rm)) : (32'(imm) & 32'hFFF);
            ill = regf && (((32'(imm) >> 4) & 32'hF) == 9);
            if (!ill)
                w = (32'(cond) << 28) | (32'(cls) << 26) | (32'(funct) << 20) | (32'(rn) << 16)
                  | (32'(rd) << 12) | low;
        end
    endfunction

    task automatic do_start();
        @(negedge clk);
        m.start = 1'b1;
        m.req_valid = 1'b0;
        @(posedge clk);
        #1;
        m.start = 1'b0;
        m_state = M_RUN;
        m_addr = 0;
        m_count = 0;
        m_err = 0;
        n_tests++;
        if (m.busy !== 1'b1 || m.done !== 1'b0 || m.err !== 1'b0 || m.count !== 7'd0 || m.imem_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL start_state: busy=%b done=%b err=%b count=%0d addr=%h, expected busy=1 done=0 err=0 count=0 addr=0",
                     m.busy, m.done, m.err, m.count, m.imem_addr);
        end
    endtask

    task automatic issue(input logic [1:0] cls, input logic md, input logic [3:0] cond, input logic [5:0] funct,
                         input logic [3:0] rd, rn, rm, rs, input logic [23:0] imm, input logic last);
        logic [31:0] w;
        logic ill;
        bit acc, exp_we;
        int unsigned exp_addr;
        ref_encode(cls, md, cond, funct, rd, rn, rm, rs, imm, w, ill);
        @(negedge clk);
        m.req_class = cls; m.req_md = md; m.req_cond = cond; m.req_funct = funct;
        m.req_rd = rd; m.req_rn = rn; m.req_rm = rm; m.req_rs = rs; m.req_imm = imm;
        m.req_last = last; m.req_valid = 1'b1;
        acc = (m_state == M_RUN) && (m_count < 64);
        n_tests++;
        if (m.req_ready !== acc) begin
            n_fail++;
            $display("FAIL req_ready: got %b expected %b", m.req_ready, acc);
        end
        @(posedge clk);
        #1;
        exp_we = acc && !ill;
        exp_addr = m_addr;
        if (acc) begin
            if (ill) m_err = 1;
            else begin
                m_addr += 4;
                m_count++;
            end
            if (last || m_count == 64) m_state = M_DONE;
        end
        n_tests++;
        if (m.imem_we !== exp_we) begin
            n_fail++;
            $display("FAIL imem_we: got %b expected %b (class=%0d md=%b)", m.imem_we, exp_we, cls, md);
        end
        if (exp_we) begin
            n_tests++;
            if (m.imem_addr !== exp_addr || m.imem_wdata !== w) begin
                n_fail++;
                $display("FAIL write: got addr=%h data=%h expected addr=%h data=%h", m.imem_addr, m.imem_wdata, exp_addr, w);
            end
        end
        n_tests++;
        if (m.count !== 7'(m_count) || m.err !== m_err || m.done !== (m_state == M_DONE) || m.busy !== (m_state == M_RUN)) begin
            n_fail++;
            $display("FAIL status: got count=%0d err=%b done=%b busy=%b expected count=%0d err=%b done=%b busy=%b",
                     m.count, m.err, m.done, m.busy, m_count, m_err, m_state == M_DONE, m_state == M_RUN);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        m.req_valid = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (m.imem_we !== 1'b0 || m.count !== 7'(m_count)) begin
            n_fail++;
            $display("FAIL idle: got we=%b count=%0d expected we=0 count=%0d", m.imem_we, m.count, m_count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (m.imem_we !== 1'b0 || m.imem_addr !== 32'd0 || m.imem_wdata !== 32'd0 || m.count !== 7'd0 ||
            m.busy !== 1'b0 || m.done !== 1'b0 || m.err !== 1'b0 || m.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: we=%b addr=%h wdata=%h count=%0d busy=%b done=%b err=%b ready=%b, expected all zero",
                     m.imem_we, m.imem_addr, m.imem_wdata, m.count, m.busy, m.done, m.err, m.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        issue(2'd0, 1'b0, 4'hE, 6'b100000, 4'd1, 4'd2, 4'd0, 4'd0, 24'h12, 1'b0);
        issue(2'd0, 1'b0, 4'hE, 6'b100000, 4'd3, 4'd4, 4'd0, 4'd0, 24'h34, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (m.imem_we !== 1'b0 || m.imem_addr !== 32'd0 || m.imem_wdata !== 32'd0 || m.count !== 7'd0 ||
            m.busy !== 1'b0 || m.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: we=%b addr=%h wdata=%h count=%0d busy=%b ready=%b, expected all zero",
                     m.imem_we, m.imem_addr, m.imem_wdata, m.count, m.busy, m.req_ready);
        end
        @(negedge clk);
        m.req_valid = 1'b0;
        rst_n = 1'b1;
        m_state = M_IDLE;
        do_start();
        issue(2'd0, 1'b0, 4'hE, 6'b100000, 4'd5, 4'd6, 4'd0, 4'd0, 24'h56, 1'b0);
    endtask

    task automatic test_dp();
        do_start();
        issue(2'd0, 1'b0, 4'hE, 6'b101000, 4'd2, 4'd1, 4'd0, 4'd0, 24'h0000FF, 1'b0);
        n_tests++;
        if (m.imem_we !== 1'b1 || m.imem_addr !== 32'd0 || m.imem_wdata !== 32'hE28120FF) begin
            n_fail++;
            $display("FAIL dp_example: got we=%b addr=%h data=%h expected we=1 addr=0 data=e28120ff",
                     m.imem_we, m.imem_addr, m.imem_wdata);
        end
        idle();
    endtask

    task automatic test_br_mem();
        logic [31:0] got_br;
        do_start();
        issue(2'd2, 1'b0, 4'hE, 6'b000000, 4'd0, 4'd0, 4'd0, 4'd0, 24'h000010, 1'b0);
        got_br = m.imem_wdata;
        issue(2'd1, 1'b0, 4'hE, 6'b011001, 4'd4, 4'd3, 4'd0, 4'd0, 24'h000008, 1'b1);
        n_tests++;
        if (got_br !== 32'hEA000010 || m.imem_wdata !== 32'hE5934008 || m.imem_addr !== 32'd4 || m.done !== 1'b1) begin
            n_fail++;
            $display("FAIL br_mem_example: got br=%h mem=%h addr=%h done=%b expected br=ea000010 mem=e5934008 addr=4 done=1",
                     got_br, m.imem_wdata, m.imem_addr, m.done);
        end
        idle();
    endtask

    task automatic test_illegal();
        do_start();
        issue(2'd0, 1'b0, 4'hE, 6'b100000, 4'd1, 4'd1, 4'd0, 4'd0, 24'h1, 1'b0);
        issue(2'd3, 1'b0, 4'hE, 6'b000000, 4'd1, 4'd1, 4'd0, 4'd0, 24'h0, 1'b0);
        issue(2'd0, 1'b0, 4'h0, 6'b000100, 4'd7, 4'd8, 4'd9, 4'd0, 24'h90, 1'b0);
        issue(2'd0, 1'b0, 4'hE, 6'b100000, 4'd2, 4'd2, 4'd0, 4'd0, 24'h2, 1'b0);
        n_tests++;
        if (m.imem_we !== 1'b1 || m.imem_addr !== 32'd4 || m.err !== 1'b1 || m.count !== 7'd2) begin
            n_fail++;
            $display("FAIL illegal_skip: got we=%b addr=%h err=%b count=%0d expected we=1 addr=4 err=1 count=2",
                     m.imem_we, m.imem_addr, m.err, m.count);
        end
        issue(2'd3, 1'b0, 4'hE, 6'b000000, 4'd0, 4'd0, 4'd0, 4'd0, 24'h0, 1'b1);
        idle();
    endtask

    task automatic test_muldiv();
        do_start();
        issue(2'd0, 1'b1, 4'hE, 6'b000000, 4'd1, 4'd0, 4'd3, 4'd2, 24'h0, 1'b0);
        n_tests++;
        if (MD_EN ? (m.imem_we !== 1'b1 || m.imem_wdata !== 32'hE0010293 || m.err !== 1'b0)
                  : (m.imem_we !== 1'b0 || m.err !== 1'b1)) begin
            n_fail++;
            $display("FAIL mul_example: got we=%b data=%h err=%b with muldiv=%b", m.imem_we, m.imem_wdata, m.err, MD_EN);
        end
        issue(2'd1, 1'b1, 4'hE, 6'b000010, 4'd0, 4'd5, 4'd6, 4'd7, 24'h0, 1'b0);
        issue(2'd2, 1'b1, 4'hE, 6'b000000, 4'd0, 4'd0, 4'd0, 4'd0, 24'h5, 1'b1);
        idle();
    endtask

    task automatic test_random();
        logic [1:0] cls;
        do_start();
        for (int i = 0; i < 50; i++) begin
            cls = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 3) cls = 2'd0;
            issue(cls, $urandom_range(0, 7) == 0, 4'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                  4'($urandom), 4'($urandom), 24'($urandom), i == 49);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
    endtask

    task automatic test_depth();
        logic [31:0] w;
        logic ill;
        @(negedge clk);
        s.start = 1'b1;
        @(posedge clk);
        #1;
        s.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ref_encode(2'd0, 1'b0, 4'hE, 6'b100000, 4'(i), 4'(i + 1), 4'd0, 4'd0, 24'(i * 3 + 1), w, ill);
            @(negedge clk);
            s.req_class = 2'd0; s.req_md = 1'b0; s.req_cond = 4'hE; s.req_funct = 6'b100000;
            s.req_rd = 4'(i); s.req_rn = 4'(i + 1); s.req_rm = 4'd0; s.req_rs = 4'd0;
            s.req_imm = 24'(i * 3 + 1); s.req_last = 1'b0; s.req_valid = 1'b1;
            n_tests++;
            if (s.req_ready !== 1'(i < 2)) begin
                n_fail++;
                $display("FAIL depth_ready[%0d]: got %b expected %b", i, s.req_ready, i < 2);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (s.imem_we !== 1'(i < 2) || (i < 2 && (s.imem_addr !== 32'(i * 4) || s.imem_wdata !== w))) begin
                n_fail++;
                $display("FAIL depth_write[%0d]: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         i, s.imem_we, s.imem_addr, s.imem_wdata, i < 2, i * 4, w);
            end
        end
        n_tests++;
        if (s.count !== 2'd2 || s.done !== 1'b1 || s.err !== 1'b0 || s.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL depth_status: got count=%0d done=%b err=%b busy=%b expected count=2 done=1 err=0 busy=0",
                     s.count, s.done, s.err, s.busy);
        end
        @(negedge clk);
        s.req_valid = 1'b0;
    endtask

    initial begin
        m.start = 0; m.req_valid = 0; m.req_last = 0; m.req_md = 0; m.req_class = 0; m.req_cond = 0;
        m.req_funct = 0; m.req_rd = 0; m.req_rn = 0; m.req_rm = 0; m.req_rs = 0; m.req_imm = 0;
        s.start = 0; s.req_valid = 0; s.req_last = 0; s.req_md = 0; s.req_class = 0; s.req_cond = 0;
        s.req_funct = 0; s.req_rd = 0; s.req_rn = 0; s.req_rm = 0; s.req_rs = 0; s.req_imm = 0;
        test_reset();
        test_dp();
        test_br_mem();
        test_illegal();
        test_muldiv();
        test_random();
        test_depth();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule
